serializador: RTL and testbench

SERIALIZADOR -- requirements
Module: serializador

---
 rtl/serializador.sv | 81 ++++++++
 tb/tb_serializador.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// serializador: parallel-to-serial shifter draining an upstream queue, one bit per write_out pulse.
// Define SERIALIZADOR_PARITY_EN to append an even-parity bit after the data bits.
module serializador #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1
) (
   input  logic              clk_10KHz,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              dequeue_out,
   input  logic              rx_busy_in,
   output logic              data_out,
   output logic              write_out,
   output logic              busy_out,
   output logic              done_out
);
`ifdef SERIALIZADOR_PARITY_EN
   localparam int FRAME = DATA_W + 1;
`else
   localparam int FRAME = DATA_W;
`endif
   localparam int CW = $clog2(FRAME + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;
   logic [DATA_W-1:0] sh;
   logic [CW-1:0] cnt;
   logic next_bit;
`ifdef SERIALIZADOR_PARITY_EN
   logic par;
   assign next_bit = (cnt == CW'(DATA_W)) ? par : (MSB_FIRST ? sh[DATA_W-1] : sh[0]);
`else
   assign next_bit = MSB_FIRST ? sh[DATA_W-1] : sh[0];
`endif
   // The SHIFT state spends one extra edge with cnt == FRAME before DONE, giving a FRAME+3 period.
   always_ff @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sh          <= '0;
         cnt         <= '0;
         data_out    <= 1'b0;
         write_out   <= 1'b0;
         dequeue_out <= 1'b0;
         busy_out    <= 1'b0;
         done_out    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
         par         <= 1'b0;
`endif
      end else begin
         write_out   <= 1'b0;
         dequeue_out <= 1'b0;
         done_out    <= 1'b0;
         case (state)
            IDLE: if (valid_in) begin
               sh          <= data_in;
               cnt         <= '0;
               state       <= SHIFT;
               dequeue_out <= 1'b1;
               busy_out    <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
               par         <= ^data_in;
`endif
            end
            SHIFT: if (cnt == CW'(FRAME)) begin
               state    <= DONE;
               done_out <= 1'b1;
            end else if (!rx_busy_in) begin
               data_out  <= next_bit;
               write_out <= 1'b1;
               cnt       <= cnt + 1'b1;
               sh        <= MSB_FIRST ? sh << 1 : sh >> 1;
            end
            DONE: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serializador.sv
// tb_serializador: directed frames with literal expectations, then random traffic against a queue model.
`timescale 1us/1ns
module tb_serializador;
   localparam int W = 8;
`ifdef SERIALIZADOR_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif
   logic clk_10KHz = 0, reset = 1, valid_in = 0, rx_busy_in = 0;
   logic [W-1:0] data_in = '0;
   logic dequeue_out, data_out, write_out, busy_out, done_out;
   logic dequeue_lsb, data_lsb, write_lsb, busy_lsb, done_lsb;
   int checks = 0, errors = 0, cyc = 0, done_n = 0;
   logic obs0[$], obs1[$];
   int wt[$], dt[$];

   serializador #(.DATA_W(W), .MSB_FIRST(1)) dut (
      .clk_10KHz(clk_10KHz), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .dequeue_out(dequeue_out), .rx_busy_in(rx_busy_in), .data_out(data_out),
      .write_out(write_out), .busy_out(busy_out), .done_out(done_out));
   serializador #(.DATA_W(W), .MSB_FIRST(0)) dut_lsb (
      .clk_10KHz(clk_10KHz), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .dequeue_out(dequeue_lsb), .rx_busy_in(rx_busy_in), .data_out(data_lsb),
      .write_out(write_lsb), .busy_out(busy_lsb), .done_out(done_lsb));

   always #50 clk_10KHz = ~clk_10KHz;
   always @(posedge clk_10KHz) cyc <= cyc + 1;

   // Reference: a frame is a queue of bits drained one per non-stalled cycle.
   logic qm[$], ql[$];
   bit framing = 0, in_done = 0;
   logic e_deq = 0, e_wr = 0, e_done = 0, e_busy = 0, e_dm = 0, e_dl = 0;
   always @(posedge clk_10KHz or posedge reset) begin
      if (reset) begin
         qm.delete(); ql.delete();
         framing = 0; in_done = 0;
         e_deq = 0; e_wr = 0; e_done = 0; e_busy = 0; e_dm = 0; e_dl = 0;
      end else begin
         e_deq = 0; e_wr = 0; e_done = 0;
         if (framing) begin
            if (qm.size() == 0) begin
               e_done = 1; framing = 0; in_done = 1;
            end else if (!rx_busy_in) begin
               e_dm = qm.pop_front(); e_dl = ql.pop_front(); e_wr = 1;
            end
         end else if (in_done) begin
            in_done = 0; e_busy = 0;
         end else if (valid_in) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back(data_in[W-1-i]);
               ql.push_back(data_in[i]);
            end
`ifdef SERIALIZADOR_PARITY_EN
            qm.push_back(^data_in);
            ql.push_back(^data_in);
`endif
            framing = 1; e_deq = 1; e_busy = 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk_10KHz) begin
      chk("dequeue_out", dequeue_out, e_deq);
      chk("write_out", write_out, e_wr);
      chk("done_out", done_out, e_done);
      chk("busy_out", busy_out, e_busy);
      chk("data_out", data_out, e_dm);
      chk("lsb_write_out", write_lsb, e_wr);
      chk("lsb_dequeue_out", dequeue_lsb, e_deq);
      chk("lsb_done_out", done_lsb, e_done);
      chk("lsb_busy_out", busy_lsb, e_busy);
      chk("lsb_data_out", data_lsb, e_dl);
      if (write_out) begin obs0.push_back(data_out); obs1.push_back(data_lsb); wt.push_back(cyc); end
      if (dequeue_out) dt.push_back(cyc);
      if (done_out) done_n++;
   end

   task automatic step;
      @(negedge clk_10KHz);
      #5;
   endtask

   task automatic clr;
      obs0.delete(); obs1.delete(); wt.delete(); dt.delete(); done_n = 0;
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (done_n < target && k < 60) begin step; k++; end
      chk("frame_done_count", done_n, target);
      step;
   endtask

   function automatic int fw(input bit lsb, input int k);
      int w = 0;
      for (int i = 0; i < W; i++) begin
         int j = k * FRAME + i;
         w = (w << 1) | ((j < obs0.size()) ? int'(lsb ? obs1[j] : obs0[j]) : 0);
      end
      return w;
   endfunction

   task automatic send(input logic [W-1:0] d);
      clr();
      valid_in = 1; data_in = d;
      step;
      valid_in = 0;
   endtask

   initial begin
      int k;
      step; step;
      chk("reset_busy", busy_out, 0);
      chk("reset_write", write_out, 0);
      reset = 0;
      step; step;
      chk("idle_no_dequeue", dt.size(), 0);
      // Plain 0xA5 frame
      send(8'hA5);
      wait_done(1);
      chk("a5_bits", fw(0, 0), 'hA5);
      chk("a5_pulses", wt.size(), FRAME);
      chk("a5_consecutive", (wt.size() == FRAME) ? wt[FRAME-1] - wt[0] : -1, FRAME - 1);
      chk("a5_dequeues", dt.size(), 1);
      chk("a5_first_bit_latency", (wt.size() > 0 && dt.size() > 0) ? wt[0] - dt[0] : -1, 1);
      chk("a5_busy_after", busy_out, 0);
      // Stall for 4 cycles after the third bit
      send(8'hA5);
      k = 0;
      while (wt.size() < 3 && k < 20) begin step; k++; end
      rx_busy_in = 1;
      repeat (4) step;
      rx_busy_in = 0;
      wait_done(1);
      chk("stall_bits", fw(0, 0), 'hA5);
      chk("stall_pulses", wt.size(), FRAME);
      chk("stall_gap", (wt.size() > 3) ? wt[3] - wt[2] : -1, 5);
      chk("stall_span", (wt.size() == FRAME) ? wt[FRAME-1] - wt[0] : -1, FRAME + 3);
      // Back-to-back 0x00 then 0xFF with valid held
      clr();
      valid_in = 1; data_in = 8'h00;
      k = 0;
      while (dt.size() < 1 && k < 10) begin step; k++; end
      data_in = 8'hFF;
      while (dt.size() < 2 && k < 40) begin step; k++; end
      valid_in = 0;
      wait_done(2);
      chk("b2b_dequeues", dt.size(), 2);
      chk("b2b_period", (dt.size() > 1) ? dt[1] - dt[0] : -1, FRAME + 3);
      chk("b2b_first", fw(0, 0), 'h00);
      chk("b2b_second", fw(0, 1), 'hFF);
      // LSB-first instance on 0x01
      send(8'h01);
      wait_done(1);
      chk("lsb_01_bits", fw(1, 0), 'h80);
      chk("msb_01_bits", fw(0, 0), 'h01);
      // Reset after 3 bits
      send(8'hA5);
      k = 0;
      while (wt.size() < 3 && k < 20) begin step; k++; end
      reset = 1;
      #1;
      chk("rst_data", data_out, 0);
      chk("rst_write", write_out, 0);
      chk("rst_dequeue", dequeue_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      step;
      reset = 0;
      repeat (FRAME + 4) step;
      chk("rst_no_done", done_n, 0);
      chk("rst_no_redequeue", dt.size(), 1);
      chk("rst_bits_lost", wt.size(), 3);
      send(8'h3C);
      wait_done(1);
      chk("post_rst_bits", fw(0, 0), 'h3C);
      chk("post_rst_pulses", wt.size(), FRAME);
`ifdef SERIALIZADOR_PARITY_EN
      send(8'h07);
      wait_done(1);
      chk("par_bits", fw(0, 0), 'h07);
      chk("par_bit", (obs0.size() > W) ? int'(obs0[W]) : -1, 1);
      chk("par_pulses", wt.size(), 9);
`endif
      // Random traffic with stalls and occasional resets
      repeat (2000) begin
         valid_in = ($urandom_range(2) != 0);
         data_in = W'($urandom);
         rx_busy_in = ($urandom_range(3) == 0);
         reset = ($urandom_range(250) == 0);
         step;
      end
      reset = 0; valid_in = 0; rx_busy_in = 0;
      repeat (FRAME + 5) step;
      chk("final_idle", busy_out, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
